// File: rtl/vga_key_painter.sv
// vga_key_painter: per-key highlight box painter with ROM-backed box restore and full-screen redraw
module vga_key_painter #(
  parameter int NUM_KEYS = 16,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COL_W = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W = 17,
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter logic [COL_W-1:0] HL_COLOUR = 3'b110,
  parameter logic [NUM_KEYS*X_W-1:0] KEY_X = '0,
  parameter logic [NUM_KEYS*Y_W-1:0] KEY_Y = '0
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [NUM_KEYS-1:0] iKeys,
  input  logic                iRedraw,
  output logic [ADDR_W-1:0]   oRomAddr,
  input  logic [COL_W-1:0]    iRomData,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COL_W-1:0]    oColour,
  output logic                oPlot,
  output logic                oBusy
);
  localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
  localparam int XW = X_W + 1;
  localparam int YW = Y_W + 1;
  typedef enum logic [1:0] {IDLE, DRAW, RESTORE, FULL} state_t;
  state_t state;
  logic [NUM_KEYS-1:0] keys_q, press_pend, rel_pend, rise, fall, press_nx, rel_nx;
  logic redraw_pend, done, p_v, go_full, go_rel, go_draw, full_exit, row_end, last, inb;
  logic [KW-1:0] r_k, p_k, sel_k;
  logic [XW-1:0] cx, bx, ex, kx;
  logic [YW-1:0] cy, ey, ky;
  logic [X_W-1:0] p_x;
  logic [Y_W-1:0] p_y;
  assign rise = iKeys & ~keys_q;
  assign fall = ~iKeys & keys_q;
  // lowest-index pending release and press
  always_comb begin
    r_k = '0;
    p_k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      r_k = rel_pend[i] ? KW'(i) : r_k;
      p_k = press_pend[i] ? KW'(i) : p_k;
    end
  end
  assign sel_k = |rel_pend ? r_k : p_k;
  assign kx = {1'b0, KEY_X[sel_k*X_W +: X_W]};
  assign ky = {1'b0, KEY_Y[sel_k*Y_W +: Y_W]};
  assign go_full = state == IDLE && redraw_pend;
  assign go_rel = state == IDLE && !redraw_pend && |rel_pend;
  assign go_draw = state == IDLE && !redraw_pend && !(|rel_pend) && |press_pend;
  assign full_exit = state == FULL && done;
  assign press_nx = ((full_exit ? iKeys : go_draw ? press_pend & ~(NUM_KEYS'(1) << p_k) : press_pend) | rise) & ~fall;
  assign rel_nx = ((full_exit ? '0 : go_rel ? rel_pend & ~(NUM_KEYS'(1) << r_k) : rel_pend) | fall) & ~rise;
  assign row_end = cx == ex;
  assign last = row_end && cy == ey;
  assign inb = cx < XW'(SCREEN_W) && cy < YW'(SCREEN_H);
  assign oRomAddr = ADDR_W'(32'(cy) * 32'(SCREEN_W) + 32'(cx));
  assign oBusy = state != IDLE;
  // edge tracking, arbitration and raster walk; ROM states run one pipeline stage behind the address
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      keys_q <= '0;
      press_pend <= '0;
      rel_pend <= '0;
      redraw_pend <= 1'b1;
      done <= 1'b0;
      cx <= '0;
      cy <= '0;
      bx <= '0;
      ex <= '0;
      ey <= '0;
      p_v <= 1'b0;
      p_x <= '0;
      p_y <= '0;
      oX <= '0;
      oY <= '0;
      oColour <= '0;
      oPlot <= 1'b0;
    end else begin
      keys_q <= iKeys;
      press_pend <= press_nx;
      rel_pend <= rel_nx;
      redraw_pend <= (redraw_pend & ~go_full) | iRedraw;
      if (state == IDLE) begin
        oPlot <= 1'b0;
        p_v <= 1'b0;
        done <= 1'b0;
        if (go_full) begin
          state <= FULL;
          cx <= '0;
          cy <= '0;
          bx <= '0;
          ex <= XW'(SCREEN_W - 1);
          ey <= YW'(SCREEN_H - 1);
        end else if (go_rel || go_draw) begin
          state <= go_rel ? RESTORE : DRAW;
          cx <= kx;
          cy <= ky;
          bx <= kx;
          ex <= kx + XW'(BOX_W - 1);
          ey <= ky + YW'(BOX_H - 1);
        end
      end else if (state == DRAW) begin
        oPlot <= inb;
        oX <= inb ? cx[X_W-1:0] : oX;
        oY <= inb ? cy[Y_W-1:0] : oY;
        oColour <= inb ? HL_COLOUR : oColour;
        cx <= row_end ? bx : cx + 1'b1;
        cy <= row_end ? cy + 1'b1 : cy;
        state <= last ? IDLE : DRAW;
      end else begin
        oPlot <= p_v;
        oX <= p_v ? p_x : oX;
        oY <= p_v ? p_y : oY;
        oColour <= p_v ? iRomData : oColour;
        p_v <= inb & ~done;
        p_x <= cx[X_W-1:0];
        p_y <= cy[Y_W-1:0];
        if (done) begin
          state <= IDLE;
        end else begin
          cx <= row_end ? bx : cx + 1'b1;
          cy <= row_end ? cy + 1'b1 : cy;
          done <= last;
        end
      end
    end
  end
endmodule
